mips_run_sequencer: RTL and testbench

Run controller for the single-cycle MIPS core and its instruction memory. It streams a program from a host valid/ready port into instruction memory and holds the core in reset while doing so. It then releases reset, counts execution cycles until the core reports `halted` or a cycle budget expires, and reports completion status. It sits between the bench/host and the core's `reset` input and the instruction-memory write port.

---
 rtl/mips_run_sequencer.sv | 159 +++++++++++++++
 tb/tb_mips_run_sequencer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_run_sequencer.sv
// mips_run_sequencer: run controller for the single-cycle MIPS core.
// Streams a program into instruction memory with the core held in reset,
// releases reset after a fixed hold, then counts execution cycles until the
// core halts or the cycle budget expires.
module mips_run_sequencer #(
   parameter int unsigned ADDR_W     = 8,
   parameter int unsigned WORD_W     = 32,
   parameter int unsigned CNT_W      = 32,
   parameter int unsigned RESET_HOLD = 7
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W:0]   prog_len,
   input  logic [CNT_W-1:0]  timeout_cycles,
   input  logic              load_valid,
   output logic              load_ready,
   input  logic [WORD_W-1:0] load_data,
   output logic              imem_wen,
   output logic [ADDR_W-1:0] imem_waddr,
   output logic [WORD_W-1:0] imem_wdata,
   output logic              cpu_reset,
   input  logic              cpu_halted,
   output logic              busy,
   output logic              done,
   output logic [1:0]        status,
   output logic [CNT_W-1:0]  cycle_count
);

   localparam int unsigned DEPTH  = 1 << ADDR_W;
   // hold counter runs 0 .. RESET_HOLD-1
   localparam int unsigned HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

   localparam logic [1:0] ST_NONE    = 2'd0;
   localparam logic [1:0] ST_HALTED  = 2'd1;
   localparam logic [1:0] ST_TIMEOUT = 2'd2;
   localparam logic [1:0] ST_BADLEN  = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_HOLD,
      S_RUN,
      S_DONE
   } state_t;

   state_t             state;
   logic [ADDR_W:0]    len_q;
   logic [CNT_W-1:0]   budget_q;
   logic [HOLD_W-1:0]  hold_cnt;

   logic               handshake;
   logic               last_word;
   logic               bad_len;
   logic               hold_last;
   logic               timeout_hit;
   logic [CNT_W-1:0]   count_next;

   // Write port is driven straight from the host handshake: no bubbles.
   assign imem_wdata  = load_data;
   assign handshake   = load_valid & load_ready;
   assign imem_wen    = handshake;

   // Decode helpers for the sequencer below.
   assign last_word   = ({1'b0, imem_waddr} == (len_q - (ADDR_W+1)'(1)));
   assign bad_len     = (prog_len == '0) || (prog_len > (ADDR_W+1)'(DEPTH));
   assign hold_last   = (hold_cnt == HOLD_W'(RESET_HOLD - 1));
   assign count_next  = cycle_count + CNT_W'(1);
   assign timeout_hit = (budget_q != '0) && (count_next == budget_q);

   // Sequencer state and all registered outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= S_IDLE;
         load_ready  <= 1'b0;
         cpu_reset   <= 1'b1;
         busy        <= 1'b0;
         done        <= 1'b0;
         imem_waddr  <= '0;
         status      <= ST_NONE;
         cycle_count <= '0;
         len_q       <= '0;
         budget_q    <= '0;
         hold_cnt    <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  len_q       <= prog_len;
                  budget_q    <= timeout_cycles;
                  status      <= ST_NONE;
                  cycle_count <= '0;
                  imem_waddr  <= '0;
                  cpu_reset   <= 1'b1;
                  if (bad_len) begin
                     state  <= S_DONE;
                     status <= ST_BADLEN;
                     done   <= 1'b1;
                     busy   <= 1'b0;
                  end else begin
                     state      <= S_LOAD;
                     load_ready <= 1'b1;
                     busy       <= 1'b1;
                     done       <= 1'b0;
                  end
               end
            end

            S_LOAD: begin
               if (handshake) begin
                  // The last word leaves the address in place so it never wraps.
                  if (last_word) begin
                     state      <= S_HOLD;
                     load_ready <= 1'b0;
                     hold_cnt   <= '0;
                  end else begin
                     imem_waddr <= imem_waddr + ADDR_W'(1);
                  end
               end
            end

            S_HOLD: begin
               if (hold_last) begin
                  state       <= S_RUN;
                  cpu_reset   <= 1'b0;
                  cycle_count <= '0;
               end else begin
                  hold_cnt <= hold_cnt + HOLD_W'(1);
               end
            end

            S_RUN: begin
               // Halt takes priority over a budget hit in the same cycle.
               if (cpu_halted) begin
                  state     <= S_DONE;
                  status    <= ST_HALTED;
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  cpu_reset <= 1'b1;
               end else begin
                  cycle_count <= count_next;
                  if (timeout_hit) begin
                     state     <= S_DONE;
                     status    <= ST_TIMEOUT;
                     done      <= 1'b1;
                     busy      <= 1'b0;
                     cpu_reset <= 1'b1;
                  end
               end
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mips_run_sequencer.sv
// Bench for mips_run_sequencer: directed load/run scenarios with a scoreboard
// of expected memory writes and expected completion records.
module tb_mips_run_sequencer;

   localparam int unsigned ADDR_W     = 8;
   localparam int unsigned WORD_W     = 32;
   localparam int unsigned CNT_W      = 32;
   localparam int unsigned RESET_HOLD = 7;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic [ADDR_W:0]   prog_len = '0;
   logic [CNT_W-1:0]  timeout_cycles = '0;
   logic              load_valid = 1'b0;
   logic              load_ready;
   logic [WORD_W-1:0] load_data = '0;
   logic              imem_wen;
   logic [ADDR_W-1:0] imem_waddr;
   logic [WORD_W-1:0] imem_wdata;
   logic              cpu_reset;
   logic              cpu_halted;
   logic              busy;
   logic              done;
   logic [1:0]        status;
   logic [CNT_W-1:0]  cycle_count;

   mips_run_sequencer #(
      .ADDR_W(ADDR_W), .WORD_W(WORD_W), .CNT_W(CNT_W), .RESET_HOLD(RESET_HOLD)
   ) dut (
      .clock(clock), .reset(reset), .start(start), .prog_len(prog_len),
      .timeout_cycles(timeout_cycles), .load_valid(load_valid),
      .load_ready(load_ready), .load_data(load_data), .imem_wen(imem_wen),
      .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .cpu_reset(cpu_reset),
      .cpu_halted(cpu_halted), .busy(busy), .done(done), .status(status),
      .cycle_count(cycle_count)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [WORD_W-1:0] data;
   } wr_t;

   typedef struct {
      logic [1:0]       st;
      logic [CNT_W-1:0] cnt;
   } dn_t;

   wr_t exp_wr[$];
   dn_t exp_dn[$];

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Stand-in core: halts once it has run halt_at cycles out of reset.
   int run_k  = 0;
   int halt_at = -1;
   always @(posedge clock) run_k <= (cpu_reset !== 1'b0) ? 0 : run_k + 1;
   assign cpu_halted = (halt_at >= 0) && (cpu_reset === 1'b0) && (run_k >= halt_at);

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   // Monitor: pops expectations whenever the DUT writes memory or completes.
   int   last_wr = 0;
   logic done_prev = 1'b0;
   logic start_prev = 1'b0;
   logic cpu_reset_prev = 1'b1;
   wr_t  mw;
   dn_t  md;
   always @(negedge clock) begin
      if (imem_wen === 1'b1) begin
         if (exp_wr.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write actual addr=%0d data=%0h expected no write",
                     imem_waddr, imem_wdata);
         end else begin
            mw = exp_wr.pop_front();
            check("wr_addr", 64'(imem_waddr), 64'(mw.addr));
            check("wr_data", 64'(imem_wdata), 64'(mw.data));
         end
         last_wr = cyc;
      end
      if (cpu_reset_prev === 1'b1 && cpu_reset === 1'b0)
         check("reset_release_delay", 64'(cyc - last_wr), 64'(RESET_HOLD + 1));
      if (done === 1'b1 && (done_prev !== 1'b1 || start_prev === 1'b1)) begin
         if (exp_dn.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done actual status=%0d expected no completion", status);
         end else begin
            md = exp_dn.pop_front();
            check("done_status", 64'(status), 64'(md.st));
            check("done_cycle_count", 64'(cycle_count), 64'(md.cnt));
         end
      end
      done_prev      = done;
      start_prev     = start;
      cpu_reset_prev = cpu_reset;
   end

   logic [WORD_W-1:0] prog [9];

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_start(input int len, input int tmo);
      start          = 1'b1;
      prog_len       = (ADDR_W+1)'(len);
      timeout_cycles = CNT_W'(tmo);
      tick();
      start = 1'b0;
   endtask

   task automatic load_words(input int n, input bit gap);
      for (int i = 0; i < n; i++) begin
         if (gap && i > 0) begin
            load_valid = 1'b0;
            load_data  = 32'hBAD0_0000 | 32'(i);
            tick();
         end
         load_valid = 1'b1;
         load_data  = prog[i];
         exp_wr.push_back('{addr: ADDR_W'(i), data: prog[i]});
         check("load_ready", 64'(load_ready), 64'(1));
         tick();
      end
      load_valid = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string name);
      int n = 0;
      while (done !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      check({name, "_done_reached"}, 64'(done), 64'(1));
      tick();
   endtask

   task automatic check_reset_vals(input string name);
      check({name, "_cpu_reset"},   64'(cpu_reset),   64'(1));
      check({name, "_load_ready"},  64'(load_ready),  64'(0));
      check({name, "_imem_wen"},    64'(imem_wen),    64'(0));
      check({name, "_busy"},        64'(busy),        64'(0));
      check({name, "_done"},        64'(done),        64'(0));
      check({name, "_imem_waddr"},  64'(imem_waddr),  64'(0));
      check({name, "_status"},      64'(status),      64'(0));
      check({name, "_cycle_count"}, 64'(cycle_count), 64'(0));
   endtask

   int t0;
   int n;

   initial begin
      // sum 1..5 into $t0, then spin on a self-branch
      prog = '{32'h2008_0000, 32'h2009_0001, 32'h200A_0006, 32'h0109_4020,
               32'h2129_0001, 32'h152A_FFFD, 32'hAC08_0000, 32'h1000_FFFF,
               32'h0000_0000};

      repeat (3) tick();
      check_reset_vals("por");
      reset = 1'b0;
      tick();

      // Host words presented while idle must not be written.
      load_valid = 1'b1;
      load_data  = 32'h1234_5678;
      repeat (3) tick();
      load_valid = 1'b0;
      check("idle_busy", 64'(busy), 64'(0));

      // 9-word program, streamed back to back, halts after 12 run cycles.
      halt_at = 12;
      exp_dn.push_back('{st: 2'd1, cnt: CNT_W'(12)});
      do_start(9, 0);
      check("t1_busy", 64'(busy), 64'(1));
      check("t1_cpu_reset_load", 64'(cpu_reset), 64'(1));
      t0 = cyc;
      load_words(9, 1'b0);
      check("t1_load_cycles", 64'(cyc - t0), 64'(9));
      wait_done(100, "t1");
      check("t1_cpu_reset_after", 64'(cpu_reset), 64'(1));
      check("t1_busy_after", 64'(busy), 64'(0));

      // 4 words with load_valid toggling; core halts in its first run cycle.
      halt_at = 0;
      exp_dn.push_back('{st: 2'd1, cnt: CNT_W'(0)});
      do_start(4, 0);
      load_words(4, 1'b1);
      wait_done(100, "t2");

      // Non-halting program against a budget of 5.
      halt_at = -1;
      exp_dn.push_back('{st: 2'd2, cnt: CNT_W'(5)});
      do_start(2, 5);
      load_words(2, 1'b0);
      wait_done(100, "t3");

      // Zero length and one-past-depth length are both rejected.
      exp_dn.push_back('{st: 2'd3, cnt: CNT_W'(0)});
      do_start(0, 0);
      check("t4a_busy", 64'(busy), 64'(0));
      check("t4a_done", 64'(done), 64'(1));
      check("t4a_load_ready", 64'(load_ready), 64'(0));
      exp_dn.push_back('{st: 2'd3, cnt: CNT_W'(0)});
      do_start(257, 0);
      check("t4b_busy", 64'(busy), 64'(0));
      check("t4b_done", 64'(done), 64'(1));
      tick();
      check("t4b_busy_later", 64'(busy), 64'(0));

      // Halt in the same cycle the count would reach the budget.
      halt_at = 5;
      exp_dn.push_back('{st: 2'd1, cnt: CNT_W'(5)});
      do_start(3, 6);
      load_words(3, 1'b0);
      wait_done(100, "t5");

      // Reset after 3 of 8 words, then a fresh load that restarts at 0.
      halt_at = -1;
      do_start(8, 0);
      load_words(3, 1'b0);
      reset = 1'b1;
      tick();
      check_reset_vals("midload");
      reset = 1'b0;
      tick();
      halt_at = 3;
      exp_dn.push_back('{st: 2'd1, cnt: CNT_W'(3)});
      do_start(2, 0);
      load_words(2, 1'b0);
      n = 0;
      while (cpu_reset !== 1'b0 && n < 50) begin
         tick();
         n++;
      end
      check("t6_run_reached", 64'(cpu_reset), 64'(0));
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(100, "t6");

      repeat (3) tick();
      check("wr_queue_empty", 64'(exp_wr.size()), 64'(0));
      check("done_queue_empty", 64'(exp_dn.size()), 64'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
